seed128_dec: RTL and testbench
==============================

Name: seed128_dec

Overview:
- Iterative SEED-128 (RFC 4269) block decryptor: 128-bit ciphertext plus 128-bit key in, 128-bit plaintext out.
- Companion to the SEED128 encryption core. It uses the same start/done handshake and port style, so the two can be swapped or paired in one datapath.
- The key schedule runs first and stores 16 round keys. The Feistel rounds then consume them in reverse order (K15 down to K0).

Parameters:
- ROUNDS, 16, number of Feistel rounds; fixed by the SEED standard, must not be overridden.

Ports:
- Clk  in  1  system clock, rising-edge
- Rst  in  1  asynchronous, active-low reset
- i_Data  in  128  ciphertext block, big-endian word order (bits 127:96 = word 0)
- i_Key  in  128  user key, same ordering
- i_fStart  in  1  start strobe; sampled only in IDLE
- o_Data  out  128  plaintext result; registered, held until the next completion
- o_fDone  out  1  one-cycle pulse when o_Data is updated
- o_fBusy  out  1  high from the cycle after start acceptance until o_fDone

Behaviour:
- Reset (Rst=0, asynchronous):
  - State goes to IDLE.
  - o_Data, o_fDone, o_fBusy, all round-key registers and all datapath registers are cleared to 0.
  - Reset mid-operation aborts the operation with no o_fDone.
- FSM states and transitions:
  - IDLE -> KEYGEN when i_fStart=1 at a rising edge. That edge latches i_Data into L/R (L = bits 127:64, R = 63:0) and i_Key into key words A,B,C,D.
  - KEYGEN, 16 cycles, counter k = 0..15. Each cycle:
    - rk[k] = {G(A+C-KC[k]), G(B-D+KC[k])}.
    - If k is even, {A,B} rotates right by 8. If k is odd, {C,D} rotates left by 8.
    - After k=15 -> ROUND.
  - ROUND, 16 cycles, counter j = 0..15. Each cycle applies (L,R) <- (R, L ^ F(R, rk[15-j])). After j=15 -> DONE.
  - DONE, 1 cycle: o_Data <= {R,L} (undoes the last swap), o_fDone=1, then -> IDLE.
- Latency: with i_fStart accepted at edge t, o_Data and o_fDone update at edge t+33.
  - o_fDone is high for exactly one cycle.
  - The earliest next start can be accepted at edge t+34.
- i_fStart while not in IDLE is ignored; there is no queuing. Holding i_fStart high continuously restarts the core every 34 cycles.
- i_Data and i_Key are sampled only at acceptance; later changes have no effect on the running block.
- F function (64-bit R = {C,D}, key {K0,K1}):
  - C' = C^K0, D' = D^K1.
  - t1 = G(C'^D'), t2 = G(C'+t1), t3 = G(t1+t2), result = {t2+t3, t3}.
  - All additions and subtractions are mod 2^32; no carries are propagated past bit 31.
- G(x) = SS0[x0]^SS1[x1]^SS2[x2]^SS3[x3], where x0 is the least significant byte.
- KC[k] constants: KC[0] = 32'h9E3779B9; each later constant is the previous one rotated left by 1.
- Round counter wrap: the 4-bit counter reaches 15 and then clears when the state changes; no 5th bit is needed.

Decomposition:
- Package seed_pkg holds:
  - FSM state encoding (IDLE/KEYGEN/ROUND/DONE)
  - KC[0..15] constant table
  - SS0..SS3 256x32 tables
  - G function
  - The same package is shared with the encryption core.
- Sub-module seed_f: combinational F function (three G instances, 32-bit mod adders). It is reusable by the encryption core.
- Key-schedule G lookups (two instances) stay in the top module.
- Round keys are held in a 16x64 register array.

Test Plan:
- Key 00000000_00000000_00000000_00000000, i_Data 5EBAC6E0_054E1668_19AFF1CC_6D346CDB -> o_Data 00010203_04050607_08090A0B_0C0D0E0F; o_fDone exactly 33 cycles after start.
- Key 00010203_04050607_08090A0B_0C0D0E0F, i_Data C11F22F2_01405050_84483597_E4370F43 -> o_Data all zeros.
- Key 47064808_51E61BE8_5D74BFB3_FD956185, i_Data EE54D13E_BCAE706D_226BC314_2CD40D4A -> o_Data 83A2F8A2_88641FB9_A4E9A5CC_2F131C7D.
- Key 28DBC3BC_49FFD87D_CFA509B1_1D422BE7, i_Data 9B9B7BFC_D1813CB9_5D0B3618_F40F5122 -> o_Data B41E6BE2_EBA84A14_8E2EED84_593C5EC7; changing i_Data/i_Key mid-run does not alter the result.
- Second i_fStart pulse at cycle 10 of a run -> ignored: one o_fDone only, result unchanged.
- Rst=0 asserted at cycle 20 of a run -> o_fDone never pulses; o_Data=0, o_fBusy=0 immediately. A fresh start after release yields the correct plaintext.

Source files
------------

// File: rtl/seed_pkg.sv
// ---------------------------------------------------------------------------
// seed_pkg : shared definitions for the SEED-128 encryption/decryption cores.
//   - FSM state encoding (IDLE / KEYGEN / ROUND / DONE)
//   - KC[0..15] key-schedule constants
//   - S1/S2 byte S-boxes and the SS0..SS3 32-bit extended S-boxes
//   - G function and 64-bit byte rotations used by the key schedule
// ---------------------------------------------------------------------------
package seed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYGEN = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } seed_state_t;

    // KC[0] is the golden-ratio constant; each later entry is the previous one rotated left by 1.
    localparam logic [31:0] KC_TAB [16] = '{
        32'h9E3779B9, 32'h3C6EF373, 32'h78DDE6E6, 32'hF1BBCDCC,
        32'hE3779B99, 32'hC6EF3733, 32'h8DDE6E67, 32'h1BBCDCCF,
        32'h3779B99E, 32'h6EF3733C, 32'hDDE6E678, 32'hBBCDCCF1,
        32'h779B99E3, 32'hEF3733C6, 32'hDE6E678D, 32'hBCDCCF1B
    };

    localparam logic [7:0] S1_TAB [256] = '{
        8'hA9,8'h85,8'hD6,8'hD3,8'h54,8'h1D,8'hAC,8'h25,8'h5D,8'h43,8'h18,8'h1E,8'h51,8'hFC,8'hCA,8'h63,
        8'h28,8'h44,8'h20,8'h9D,8'hE0,8'hE2,8'hC8,8'h17,8'hA5,8'h8F,8'h03,8'h7B,8'hBB,8'h13,8'hD2,8'hEE,
        8'h70,8'h8C,8'h3F,8'hA8,8'h32,8'hDD,8'hF6,8'h74,8'hEC,8'h95,8'h0B,8'h57,8'h5C,8'h5B,8'hBD,8'h01,
        8'h24,8'h1C,8'h73,8'h98,8'h10,8'hCC,8'hF2,8'hD9,8'h2C,8'hE7,8'h72,8'h83,8'h9B,8'hD1,8'h86,8'hC9,
        8'h60,8'h50,8'hA3,8'hEB,8'h0D,8'hB6,8'h9E,8'h4F,8'hB7,8'h5A,8'hC6,8'h78,8'hA6,8'h12,8'hAF,8'hD5,
        8'h61,8'hC3,8'hB4,8'h41,8'h52,8'h7D,8'h8D,8'h08,8'h1F,8'h99,8'h00,8'h19,8'h04,8'h53,8'hF7,8'hE1,
        8'hFD,8'h76,8'h2F,8'h27,8'hB0,8'h8B,8'h0E,8'hAB,8'hA2,8'h6E,8'h93,8'h4D,8'h69,8'h7C,8'h09,8'h0A,
        8'hBF,8'hEF,8'hF3,8'hC5,8'h87,8'h14,8'hFE,8'h64,8'hDE,8'h2E,8'h4B,8'h1A,8'h06,8'h21,8'h6B,8'h66,
        8'h02,8'hF5,8'h92,8'h8A,8'h0C,8'hB3,8'h7E,8'hD0,8'h7A,8'h47,8'h96,8'hE5,8'h26,8'h80,8'hAD,8'hDF,
        8'hA1,8'h30,8'h37,8'hAE,8'h36,8'h15,8'h22,8'h38,8'hF4,8'hA7,8'h45,8'h4C,8'h81,8'hE9,8'h84,8'h97,
        8'h35,8'hCB,8'hCE,8'h3C,8'h71,8'h11,8'hC7,8'h89,8'h75,8'hFB,8'hDA,8'hF8,8'h94,8'h59,8'h82,8'hC4,
        8'hFF,8'h49,8'h39,8'h67,8'hC0,8'hCF,8'hD7,8'hB8,8'h0F,8'h8E,8'h42,8'h23,8'h91,8'h6C,8'hDB,8'hA4,
        8'h34,8'hF1,8'h48,8'hC2,8'h6F,8'h3D,8'h2D,8'h40,8'hBE,8'h3E,8'hBC,8'hC1,8'hAA,8'hBA,8'h4E,8'h55,
        8'h3B,8'hDC,8'h68,8'h7F,8'h9C,8'hD8,8'h4A,8'h56,8'h77,8'hA0,8'hED,8'h46,8'hB5,8'h2B,8'h65,8'hFA,
        8'hE3,8'hB9,8'hB1,8'h9F,8'h5E,8'hF9,8'hE6,8'hB2,8'h31,8'hEA,8'h6D,8'h5F,8'hE4,8'hF0,8'hCD,8'h88,
        8'h16,8'h3A,8'h58,8'hD4,8'h62,8'h29,8'h07,8'h33,8'hE8,8'h1B,8'h05,8'h79,8'h90,8'h6A,8'h2A,8'h9A
    };

    localparam logic [7:0] S2_TAB [256] = '{
        8'h38,8'hE8,8'h2D,8'hA6,8'hCF,8'hDE,8'hB3,8'hB8,8'hAF,8'h60,8'h55,8'hC7,8'h44,8'h6F,8'h6B,8'h5B,
        8'hC3,8'h62,8'h33,8'hB5,8'h29,8'hA0,8'hE2,8'hA7,8'hD3,8'h91,8'h11,8'h06,8'h1C,8'hBC,8'h36,8'h4B,
        8'hEF,8'h88,8'h6C,8'hA8,8'h17,8'hC4,8'h16,8'hF4,8'hC2,8'h45,8'hE1,8'hD6,8'h3F,8'h3D,8'h8E,8'h98,
        8'h28,8'h4E,8'hF6,8'h3E,8'hA5,8'hF9,8'h0D,8'hDF,8'hD8,8'h2B,8'h66,8'h7A,8'h27,8'h2F,8'hF1,8'h72,
        8'h42,8'hD4,8'h41,8'hC0,8'h73,8'h67,8'hAC,8'h8B,8'hF7,8'hAD,8'h80,8'h1F,8'hCA,8'h2C,8'hAA,8'h34,
        8'hD2,8'h0B,8'hEE,8'hE9,8'h5D,8'h94,8'h18,8'hF8,8'h57,8'hAE,8'h08,8'hC5,8'h13,8'hCD,8'h86,8'hB9,
        8'hFF,8'h7D,8'hC1,8'h31,8'hF5,8'h8A,8'h6A,8'hB1,8'hD1,8'h20,8'hD7,8'h02,8'h22,8'h04,8'h68,8'h71,
        8'h07,8'hDB,8'h9D,8'h99,8'h61,8'hBE,8'hE6,8'h59,8'hDD,8'h51,8'h90,8'hDC,8'h9A,8'hA3,8'hAB,8'hD0,
        8'h81,8'h0F,8'h47,8'h1A,8'hE3,8'hEC,8'h8D,8'hBF,8'h96,8'h7B,8'h5C,8'hA2,8'hA1,8'h63,8'h23,8'h4D,
        8'hC8,8'h9E,8'h9C,8'h3A,8'h0C,8'h2E,8'hBA,8'h6E,8'h9F,8'h5A,8'hF2,8'h92,8'hF3,8'h49,8'h78,8'hCC,
        8'h15,8'hFB,8'h70,8'h75,8'h7F,8'h35,8'h10,8'h03,8'h64,8'h6D,8'hC6,8'h74,8'hD5,8'hB4,8'hEA,8'h09,
        8'h76,8'h19,8'hFE,8'h40,8'h12,8'hE0,8'hBD,8'h05,8'hFA,8'h01,8'hF0,8'h2A,8'h5E,8'hA9,8'h56,8'h43,
        8'h85,8'h14,8'h89,8'h9B,8'hB0,8'hE5,8'h48,8'h79,8'h97,8'hFC,8'h1E,8'h82,8'h21,8'h8C,8'h1B,8'h5F,
        8'h77,8'h54,8'hB2,8'h1D,8'h25,8'h4F,8'h00,8'h46,8'hED,8'h58,8'h52,8'hEB,8'h7E,8'hDA,8'hC9,8'hFD,
        8'h30,8'h95,8'h65,8'h3C,8'hB6,8'hE4,8'hBB,8'h7C,8'h0E,8'h50,8'h39,8'h26,8'h32,8'h84,8'h69,8'h93,
        8'h37,8'hE7,8'h24,8'hA4,8'hCB,8'h53,8'h0A,8'h87,8'hD9,8'h4C,8'h83,8'h8F,8'hCE,8'h3B,8'h4A,8'hB7
    };

    // SS0..SS3 are the S-box outputs spread over four bytes with the masks
    // m0=FC, m1=F3, m2=CF, m3=3F; deriving them here avoids four 1 KiB literal tables.
    function automatic logic [31:0] ss0(input logic [7:0] x);
        logic [7:0] s_s;
        s_s = S1_TAB[x];
        return {s_s & 8'h3F, s_s & 8'hCF, s_s & 8'hF3, s_s & 8'hFC};
    endfunction

    function automatic logic [31:0] ss1(input logic [7:0] x);
        logic [7:0] s_s;
        s_s = S2_TAB[x];
        return {s_s & 8'hFC, s_s & 8'h3F, s_s & 8'hCF, s_s & 8'hF3};
    endfunction

    function automatic logic [31:0] ss2(input logic [7:0] x);
        logic [7:0] s_s;
        s_s = S1_TAB[x];
        return {s_s & 8'hF3, s_s & 8'hFC, s_s & 8'h3F, s_s & 8'hCF};
    endfunction

    function automatic logic [31:0] ss3(input logic [7:0] x);
        logic [7:0] s_s;
        s_s = S2_TAB[x];
        return {s_s & 8'hCF, s_s & 8'hF3, s_s & 8'hFC, s_s & 8'h3F};
    endfunction

    // G function; x[7:0] is the least significant byte x0.
    function automatic logic [31:0] g_func(input logic [31:0] x);
        return ss0(x[7:0]) ^ ss1(x[15:8]) ^ ss2(x[23:16]) ^ ss3(x[31:24]);
    endfunction

    function automatic logic [63:0] rotr8_64(input logic [63:0] x);
        return {x[7:0], x[63:8]};
    endfunction

    function automatic logic [63:0] rotl8_64(input logic [63:0] x);
        return {x[55:0], x[63:56]};
    endfunction

endpackage

// File: rtl/seed_f.sv
// ---------------------------------------------------------------------------
// seed_f : combinational SEED F function, shared by encryption and decryption.
// Ports:
//   r   [63:0]  right half {C,D}
//   key [63:0]  round key {K0,K1}
//   f   [63:0]  F result {t2+t3, t3}
// All sums are modulo 2^32.
// ---------------------------------------------------------------------------
module seed_f
    import seed_pkg::*;
(
    input  logic [63:0] r,
    input  logic [63:0] key,
    output logic [63:0] f
);

    logic [31:0] c_s;
    logic [31:0] d_s;
    logic [31:0] t1_s;
    logic [31:0] t2_s;
    logic [31:0] t3_s;
    logic [31:0] sum1_s;
    logic [31:0] sum2_s;
    logic [31:0] sum3_s;

    // Three chained G stages with 32-bit wrap-around additions between them.
    always_comb begin
        c_s    = r[63:32] ^ key[63:32];
        d_s    = r[31:0]  ^ key[31:0];
        t1_s   = g_func(c_s ^ d_s);
        sum1_s = c_s + t1_s;
        t2_s   = g_func(sum1_s);
        sum2_s = t1_s + t2_s;
        t3_s   = g_func(sum2_s);
        sum3_s = t2_s + t3_s;
        f      = {sum3_s, t3_s};
    end

endmodule

// File: rtl/seed128_dec.sv
// ---------------------------------------------------------------------------
// seed128_dec : iterative SEED-128 block decryptor.
// A start in IDLE latches ciphertext and key; 16 key-schedule cycles fill the
// round-key array, 16 Feistel rounds consume the keys in reverse order, and a
// final cycle publishes the plaintext. Result appears 33 edges after start.
// Ports:
//   Clk       rising-edge clock
//   Rst       asynchronous active-low reset
//   i_Data    [127:0] ciphertext, bits 127:96 = word 0
//   i_Key     [127:0] user key, same ordering
//   i_fStart  start strobe, only looked at in IDLE
//   o_Data    [127:0] registered plaintext, held until the next completion
//   o_fDone   one-cycle pulse when o_Data updates
//   o_fBusy   high from the cycle after acceptance until o_fDone
// ---------------------------------------------------------------------------
module seed128_dec
    import seed_pkg::*;
#(
    parameter int ROUNDS = 16
)(
    input  logic         Clk,
    input  logic         Rst,
    input  logic [127:0] i_Data,
    input  logic [127:0] i_Key,
    input  logic         i_fStart,
    output logic [127:0] o_Data,
    output logic         o_fDone,
    output logic         o_fBusy
);

    localparam logic [3:0] CNT_LAST = 4'(ROUNDS - 1);

    seed_state_t  state_r;
    seed_state_t  state_s;
    logic [3:0]   cnt_r;
    logic [31:0]  a_r;
    logic [31:0]  b_r;
    logic [31:0]  c_r;
    logic [31:0]  d_r;
    logic [63:0]  l_r;
    logic [63:0]  r_r;
    logic [63:0]  rk_r [16];
    logic [127:0] data_r;
    logic         done_r;
    logic         busy_r;

    logic [31:0]  kc_s;
    logic [31:0]  ks_x0_s;
    logic [31:0]  ks_x1_s;
    logic [63:0]  rk_new_s;
    logic [63:0]  rk_sel_s;
    logic [63:0]  f_s;
    logic [63:0]  ab_rot_s;
    logic [63:0]  cd_rot_s;

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_fStart) begin
                    state_s = ST_KEYGEN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_KEYGEN: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_ROUND;
                end else begin
                    state_s = ST_KEYGEN;
                end
            end
            ST_ROUND: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ROUND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Key-schedule G inputs, byte rotations and reverse-order round-key select.
    always_comb begin
        kc_s     = KC_TAB[cnt_r];
        ks_x0_s  = a_r + c_r - kc_s;
        ks_x1_s  = b_r - d_r + kc_s;
        rk_new_s = {g_func(ks_x0_s), g_func(ks_x1_s)};
        ab_rot_s = rotr8_64({a_r, b_r});
        cd_rot_s = rotl8_64({c_r, d_r});
        // Decryption walks the schedule backwards: K15 first.
        rk_sel_s = rk_r[CNT_LAST - cnt_r];
    end

    seed_f u_f (
        .r   (r_r),
        .key (rk_sel_s),
        .f   (f_s)
    );

    // Datapath, round-key array and registered outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_r  <= 4'd0;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            c_r    <= 32'd0;
            d_r    <= 32'd0;
            l_r    <= 64'd0;
            r_r    <= 64'd0;
            data_r <= 128'd0;
            done_r <= 1'b0;
            busy_r <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rk_r[i] <= 64'd0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_fStart) begin
                        l_r    <= i_Data[127:64];
                        r_r    <= i_Data[63:0];
                        a_r    <= i_Key[127:96];
                        b_r    <= i_Key[95:64];
                        c_r    <= i_Key[63:32];
                        d_r    <= i_Key[31:0];
                        cnt_r  <= 4'd0;
                        busy_r <= 1'b1;
                    end
                end
                ST_KEYGEN: begin
                    rk_r[cnt_r] <= rk_new_s;
                    // Even steps rotate {A,B}, odd steps rotate {C,D}.
                    if (cnt_r[0] == 1'b0) begin
                        {a_r, b_r} <= ab_rot_s;
                    end else begin
                        {c_r, d_r} <= cd_rot_s;
                    end
                    // The 4-bit counter wraps 15 -> 0 exactly as the state changes.
                    cnt_r <= cnt_r + 4'd1;
                end
                ST_ROUND: begin
                    l_r   <= r_r;
                    r_r   <= l_r ^ f_s;
                    cnt_r <= cnt_r + 4'd1;
                end
                ST_DONE: begin
                    // Swapping halves undoes the swap of the final round.
                    data_r <= {r_r, l_r};
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_Data  = data_r;
    assign o_fDone = done_r;
    assign o_fBusy = busy_r;

endmodule

// File: tb/tb_seed128_dec.sv
module tb_seed128_dec;

    logic         Clk;
    logic         Rst;
    logic [127:0] i_Data;
    logic [127:0] i_Key;
    logic         i_fStart;
    logic [127:0] o_Data;
    logic         o_fDone;
    logic         o_fBusy;

    int n_checks;
    int n_fail;

    logic [127:0] kv_key [4];
    logic [127:0] kv_ct  [4];
    logic [127:0] kv_pt  [4];

    seed128_dec dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .i_Data   (i_Data),
        .i_Key    (i_Key),
        .i_fStart (i_fStart),
        .o_Data   (o_Data),
        .o_fDone  (o_fDone),
        .o_fBusy  (o_fBusy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pulse start for one edge; returns at the negedge right after acceptance.
    task automatic start_block(input logic [127:0] key, input logic [127:0] ct);
        @(negedge Clk);
        i_Key    = key;
        i_Data   = ct;
        i_fStart = 1'b1;
        @(negedge Clk);
        i_fStart = 1'b0;
    endtask

    // Bounded wait for o_fDone; lat = -1 when nothing arrives.
    task automatic wait_done(output int lat, output logic [127:0] res);
        lat = -1;
        res = 128'd0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge Clk);
            if (o_fDone === 1'b1) begin
                lat = c;
                res = o_Data;
                break;
            end
        end
    endtask

    task automatic test_reset;
        Rst      = 1'b0;
        i_fStart = 1'b0;
        i_Data   = 128'd0;
        i_Key    = 128'd0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if (o_Data !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected %h", o_Data, 128'd0);
        end
        n_checks++;
        if (o_fDone !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: got %b expected 0", o_fDone);
        end
        n_checks++;
        if (o_fBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", o_fBusy);
        end
        Rst = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_vectors;
        int           lat;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) begin
            start_block(kv_key[i], kv_ct[i]);
            n_checks++;
            if (o_fBusy !== 1'b1) begin
                n_fail++;
                $display("FAIL kat%0d_busy_start: got %b expected 1", i, o_fBusy);
            end
            wait_done(lat, res);
            n_checks++;
            if (lat !== 33) begin
                n_fail++;
                $display("FAIL kat%0d_latency: got %0d expected 33", i, lat);
            end
            n_checks++;
            if (res !== kv_pt[i]) begin
                n_fail++;
                $display("FAIL kat%0d_data: got %h expected %h", i, res, kv_pt[i]);
            end
            n_checks++;
            if (o_fBusy !== 1'b0) begin
                n_fail++;
                $display("FAIL kat%0d_busy_done: got %b expected 0", i, o_fBusy);
            end
            @(negedge Clk);
            n_checks++;
            if (o_fDone !== 1'b0) begin
                n_fail++;
                $display("FAIL kat%0d_done_width: got %b expected 0", i, o_fDone);
            end
            n_checks++;
            if (o_Data !== kv_pt[i]) begin
                n_fail++;
                $display("FAIL kat%0d_data_hold: got %h expected %h", i, o_Data, kv_pt[i]);
            end
        end
    endtask

    task automatic test_input_change;
        int           lat;
        logic [127:0] res;
        start_block(kv_key[3], kv_ct[3]);
        lat = -1;
        res = 128'd0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge Clk);
            if (c == 5) begin
                i_Data = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
                i_Key  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
            end
            if (c == 20) begin
                i_Data = 128'd0;
                i_Key  = 128'd0;
            end
            if (o_fDone === 1'b1) begin
                lat = c;
                res = o_Data;
                break;
            end
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL chg_latency: got %0d expected 33", lat);
        end
        n_checks++;
        if (res !== kv_pt[3]) begin
            n_fail++;
            $display("FAIL chg_data: got %h expected %h", res, kv_pt[3]);
        end
    endtask

    task automatic test_ignore_start;
        int           lat;
        int           n_done;
        logic [127:0] res;
        start_block(kv_key[0], kv_ct[0]);
        lat    = -1;
        n_done = 0;
        res    = 128'd0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge Clk);
            if (o_fDone === 1'b1) begin
                n_done++;
                if (lat < 0) begin
                    lat = c;
                    res = o_Data;
                end
            end
            if (c == 10) begin
                i_Key    = kv_key[1];
                i_Data   = kv_ct[1];
                i_fStart = 1'b1;
            end
            if (c == 11) begin
                i_fStart = 1'b0;
            end
        end
        n_checks++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL ign_done_count: got %0d expected 1", n_done);
        end
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL ign_latency: got %0d expected 33", lat);
        end
        n_checks++;
        if (res !== kv_pt[0]) begin
            n_fail++;
            $display("FAIL ign_data: got %h expected %h", res, kv_pt[0]);
        end
        n_checks++;
        if (o_fBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_busy_end: got %b expected 0", o_fBusy);
        end
    endtask

    task automatic test_midrun_reset;
        int           lat;
        int           n_done;
        logic [127:0] res;
        // o_Data holds a non-zero plaintext from the previous run here.
        start_block(kv_key[2], kv_ct[2]);
        n_done = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            if (o_fDone === 1'b1) n_done++;
        end
        Rst = 1'b0;
        #1;
        n_checks++;
        if (o_Data !== 128'd0) begin
            n_fail++;
            $display("FAIL rst_mid_data: got %h expected %h", o_Data, 128'd0);
        end
        n_checks++;
        if (o_fBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_busy: got %b expected 0", o_fBusy);
        end
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge Clk);
            if (o_fDone === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: got %0d expected 0", n_done);
        end
        start_block(kv_key[2], kv_ct[2]);
        wait_done(lat, res);
        n_checks++;
        if (lat !== 33) begin
            n_fail++;
            $display("FAIL rst_fresh_latency: got %0d expected 33", lat);
        end
        n_checks++;
        if (res !== kv_pt[2]) begin
            n_fail++;
            $display("FAIL rst_fresh_data: got %h expected %h", res, kv_pt[2]);
        end
    endtask

    task automatic test_back_to_back;
        int           lat1;
        int           lat2;
        logic [127:0] res1;
        logic [127:0] res2;
        logic         busy33;
        logic         busy34;
        lat1   = -1;
        lat2   = -1;
        res1   = 128'd0;
        res2   = 128'd0;
        busy33 = 1'bx;
        busy34 = 1'bx;
        @(negedge Clk);
        i_Key    = kv_key[0];
        i_Data   = kv_ct[0];
        i_fStart = 1'b1;
        @(negedge Clk);
        // Second block is sampled only when the core returns to IDLE.
        i_Key  = kv_key[1];
        i_Data = kv_ct[1];
        for (int c = 1; c <= 70; c++) begin
            @(negedge Clk);
            if (c == 33) busy33 = o_fBusy;
            if (c == 34) busy34 = o_fBusy;
            if (o_fDone === 1'b1) begin
                if (lat1 < 0) begin
                    lat1 = c;
                    res1 = o_Data;
                end else if (lat2 < 0) begin
                    lat2 = c;
                    res2 = o_Data;
                end
            end
            if (c == 67) i_fStart = 1'b0;
        end
        n_checks++;
        if (lat1 !== 33) begin
            n_fail++;
            $display("FAIL b2b_latency1: got %0d expected 33", lat1);
        end
        n_checks++;
        if (res1 !== kv_pt[0]) begin
            n_fail++;
            $display("FAIL b2b_data1: got %h expected %h", res1, kv_pt[0]);
        end
        n_checks++;
        if (lat2 !== 67) begin
            n_fail++;
            $display("FAIL b2b_latency2: got %0d expected 67", lat2);
        end
        n_checks++;
        if (res2 !== kv_pt[1]) begin
            n_fail++;
            $display("FAIL b2b_data2: got %h expected %h", res2, kv_pt[1]);
        end
        n_checks++;
        if (busy33 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_at_done: got %b expected 0", busy33);
        end
        n_checks++;
        if (busy34 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_busy_restart: got %b expected 1", busy34);
        end
        n_checks++;
        if (o_fBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_after: got %b expected 0", o_fBusy);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        kv_key[0] = 128'h00000000_00000000_00000000_00000000;
        kv_ct[0]  = 128'h5EBAC6E0_054E1668_19AFF1CC_6D346CDB;
        kv_pt[0]  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        kv_key[1] = 128'h00010203_04050607_08090A0B_0C0D0E0F;
        kv_ct[1]  = 128'hC11F22F2_01405050_84483597_E4370F43;
        kv_pt[1]  = 128'h00000000_00000000_00000000_00000000;
        kv_key[2] = 128'h47064808_51E61BE8_5D74BFB3_FD956185;
        kv_ct[2]  = 128'hEE54D13E_BCAE706D_226BC314_2CD40D4A;
        kv_pt[2]  = 128'h83A2F8A2_88641FB9_A4E9A5CC_2F131C7D;
        kv_key[3] = 128'h28DBC3BC_49FFD87D_CFA509B1_1D422BE7;
        kv_ct[3]  = 128'h9B9B7BFC_D1813CB9_5D0B3618_F40F5122;
        kv_pt[3]  = 128'hB41E6BE2_EBA84A14_8E2EED84_593C5EC7;

        test_reset();
        test_vectors();
        test_input_change();
        test_ignore_start();
        test_midrun_reset();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
